// File: rtl/kgp_dbg_pkg.sv
// kgp_dbg_pkg
// Shared constants for the KGPminiRISC debug controller:
//   - run-control FSM state encodings (RUN, HALTED, STEP, READ_WAIT)
//   - dbg_sel observation source codes
package kgp_dbg_pkg;

    typedef logic [1:0] dbg_state_t;

    localparam dbg_state_t ST_RUN       = 2'd0;
    localparam dbg_state_t ST_HALTED    = 2'd1;
    localparam dbg_state_t ST_STEP      = 2'd2;
    localparam dbg_state_t ST_READ_WAIT = 2'd3;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC  = 2'd2;
    localparam logic [1:0] SEL_CYC = 2'd3;

endpackage

// File: rtl/kgp_dbg_slice_mux.sv
// kgp_dbg_slice_mux
// Purely combinational window select: picks OUT_W-bit slice number `slice`
// out of a DATA_W-bit word. The last partial slice is zero-padded above
// DATA_W, and slice indices past the last slice return zero.
// Ports:
//   data    in   DATA_W   word to be windowed
//   slice   in   SLICE_W  window index
//   window  out  OUT_W    selected window
module kgp_dbg_slice_mux #(
    parameter int DATA_W  = 32,
    parameter int OUT_W   = 16,
    parameter int SLICE_W = 2
) (
    input  logic [DATA_W-1:0]  data,
    input  logic [SLICE_W-1:0] slice,
    output logic [OUT_W-1:0]   window
);

    localparam int NSLICE = (DATA_W + OUT_W - 1) / OUT_W;

    logic [NSLICE*OUT_W-1:0] padded;

    always_comb begin
        padded              = '0;
        padded[DATA_W-1:0]  = data;
        window              = '0;
        // Unmatched indices (>= NSLICE) leave the window at zero.
        for (int i = 0; i < NSLICE; i++) begin
            if (int'(slice) == i) begin
                window = padded[i*OUT_W +: OUT_W];
            end
        end
    end

endmodule

// File: rtl/kgp_debug_ctrl.sv
// kgp_debug_ctrl
// Run-control and observation unit between board pins and the KGPminiRISC
// core. Gates core_ce in run / halt / single-step / PC-breakpoint modes and
// presents regfile, data memory, PC or cycle count through an OUT_W window.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   run, halt, step          board controls (halt > step > run; step is edge)
//   bp_en, bp_addr           PC breakpoint
//   core_pc, core_halt_instr core status
//   core_ce, halted          core clock-enable, HALTED indication
//   dbg_sel/addr/slice       observation select, address, window index
//   rf_raddr, rf_rdata       regfile debug read port
//   mem_rd_req/raddr/ack/rdata  dmem debug read handshake
//   out, cycle_cnt           display window, retired-instruction counter
//   dbg_state                current FSM state
module kgp_debug_ctrl
    import kgp_dbg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OUT_W    = 16,
    parameter int SLICE_W  = 2,
    parameter int ADDR_W   = 10,
    parameter int RF_AW    = 5,
    parameter int PC_W     = 32,
    parameter int CYC_W    = 32,
    parameter int AUTO_RUN = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               halt,
    input  logic               step,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    core_pc,
    input  logic               core_halt_instr,
    output logic               core_ce,
    output logic               halted,
    input  logic [1:0]         dbg_sel,
    input  logic [ADDR_W-1:0]  dbg_addr,
    input  logic [SLICE_W-1:0] dbg_slice,
    output logic [RF_AW-1:0]   rf_raddr,
    input  logic [DATA_W-1:0]  rf_rdata,
    output logic               mem_rd_req,
    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic               mem_rd_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [OUT_W-1:0]   out,
    output logic [CYC_W-1:0]   cycle_cnt,
    output logic [1:0]         dbg_state
);

    localparam dbg_state_t ST_RESET = (AUTO_RUN != 0) ? ST_RUN : ST_HALTED;

    dbg_state_t         state_q, state_d;
    logic               step_q, step_d;
    logic               bp_skip_q, bp_skip_d;
    logic               arm_q, arm_d;       // HALTED was just entered from RUN/STEP
    logic               track_q, track_d;   // prev-select registers hold real history
    logic [1:0]         sel_prev_q, sel_prev_d;
    logic [ADDR_W-1:0]  addr_prev_q, addr_prev_d;
    logic [ADDR_W-1:0]  mem_raddr_q, mem_raddr_d;
    logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [DATA_W-1:0]  capture_q, capture_d;
    logic [OUT_W-1:0]   out_q, out_d;

    logic               step_rise;
    logic               bp_hit;
    logic               sel_changed;
    logic               read_trig;
    logic [DATA_W-1:0]  pc_ext;
    logic [DATA_W-1:0]  cyc_ext;
    logic [OUT_W-1:0]   window;

    // Zero-extend or truncate PC and cycle counter to the observed word width.
    if (PC_W >= DATA_W) begin : g_pc_trunc
        assign pc_ext = core_pc[DATA_W-1:0];
    end else begin : g_pc_pad
        assign pc_ext = {{(DATA_W-PC_W){1'b0}}, core_pc};
    end

    if (CYC_W >= DATA_W) begin : g_cyc_trunc
        assign cyc_ext = cycle_cnt_q[DATA_W-1:0];
    end else begin : g_cyc_pad
        assign cyc_ext = {{(DATA_W-CYC_W){1'b0}}, cycle_cnt_q};
    end

    assign step_rise   = step && !step_q;
    assign bp_hit      = bp_en && (core_pc == bp_addr) && !bp_skip_q;
    assign sel_changed = track_q && ((dbg_sel != sel_prev_q) || (dbg_addr != addr_prev_q));
    assign read_trig   = (dbg_sel == SEL_MEM) && (arm_q || sel_changed);

    // Run-control FSM.
    always_comb begin
        state_d     = state_q;
        core_ce     = 1'b0;
        arm_d       = arm_q;
        mem_raddr_d = mem_raddr_q;
        case (state_q)
            ST_RUN: begin
                // Breakpoint instruction and halt both stop before retiring.
                if (halt || bp_hit) begin
                    state_d = ST_HALTED;
                    arm_d   = 1'b1;
                end else begin
                    core_ce = 1'b1;
                    // The HALT opcode itself retires, then we stop.
                    if (core_halt_instr) begin
                        state_d = ST_HALTED;
                        arm_d   = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                arm_d = 1'b0;
                if (!halt && step_rise) begin
                    state_d = ST_STEP;
                end else if (!halt && run) begin
                    state_d = ST_RUN;
                end else if (read_trig) begin
                    state_d     = ST_READ_WAIT;
                    mem_raddr_d = dbg_addr;
                end
            end
            ST_STEP: begin
                core_ce = 1'b1;
                state_d = ST_HALTED;
                arm_d   = 1'b1;
            end
            ST_READ_WAIT: begin
                // Controls are ignored until the memory answers.
                if (mem_rd_ack) begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    // Leaving HALTED arms a one-shot breakpoint bypass so that resuming on a
    // breakpoint PC executes that instruction once instead of re-hitting it.
    always_comb begin
        bp_skip_d = bp_skip_q;
        if (state_q == ST_HALTED && state_d != ST_HALTED) begin
            bp_skip_d = 1'b1;
        end else if (core_ce) begin
            bp_skip_d = 1'b0;
        end
    end

    // Counter, history and capture/window registers.
    always_comb begin
        step_d      = step;
        track_d     = 1'b1;
        sel_prev_d  = dbg_sel;
        addr_prev_d = dbg_addr;
        cycle_cnt_d = core_ce ? cycle_cnt_q + CYC_W'(1) : cycle_cnt_q;
        capture_d   = capture_q;
        case (dbg_sel)
            SEL_RF:  capture_d = rf_rdata;
            SEL_MEM: begin
                if (state_q == ST_READ_WAIT && mem_rd_ack) begin
                    capture_d = mem_rdata;
                end
            end
            SEL_PC:  capture_d = pc_ext;
            default: capture_d = cyc_ext;
        endcase
        out_d = window;
    end

    kgp_dbg_slice_mux #(
        .DATA_W  (DATA_W),
        .OUT_W   (OUT_W),
        .SLICE_W (SLICE_W)
    ) u_slice_mux (
        .data   (capture_q),
        .slice  (dbg_slice),
        .window (window)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RESET;
            step_q      <= 1'b0;
            bp_skip_q   <= 1'b0;
            arm_q       <= 1'b0;
            track_q     <= 1'b0;
            sel_prev_q  <= '0;
            addr_prev_q <= '0;
            mem_raddr_q <= '0;
            cycle_cnt_q <= '0;
            capture_q   <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            bp_skip_q   <= bp_skip_d;
            arm_q       <= arm_d;
            track_q     <= track_d;
            sel_prev_q  <= sel_prev_d;
            addr_prev_q <= addr_prev_d;
            mem_raddr_q <= mem_raddr_d;
            cycle_cnt_q <= cycle_cnt_d;
            capture_q   <= capture_d;
            out_q       <= out_d;
        end
    end

    // Debug read handshake: mem_rd_req is high for every cycle spent in
    // READ_WAIT with mem_raddr stable; the cycle in which mem_rd_ack is high
    // transfers mem_rdata, and req drops on the following cycle. Because req
    // decodes the asynchronously reset state register, rst removes it at once.
    assign mem_rd_req = (state_q == ST_READ_WAIT);
    assign mem_raddr  = mem_raddr_q;
    assign halted     = (state_q == ST_HALTED);
    assign rf_raddr   = dbg_addr[RF_AW-1:0];
    assign out        = out_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_kgp_debug_ctrl.sv
// tb_kgp_debug_ctrl
// Self-checking bench for kgp_debug_ctrl (CYC_W=4 so the counter wrap is
// reachable). Window outputs go through an expected-value queue; control
// corner cases are hand-written sequences.
module tb_kgp_debug_ctrl;

    localparam int DATA_W  = 32;
    localparam int OUT_W   = 16;
    localparam int SLICE_W = 2;
    localparam int ADDR_W  = 10;
    localparam int RF_AW   = 5;
    localparam int PC_W    = 32;
    localparam int CYC_W   = 4;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_HALT = 2'd1;
    localparam logic [1:0] S_RDW  = 2'd3;

    logic               clk = 1'b0;
    logic               rst;
    logic               run, halt, step, bp_en;
    logic [PC_W-1:0]    bp_addr, core_pc;
    logic               core_halt_instr;
    logic               core_ce, halted;
    logic [1:0]         dbg_sel;
    logic [ADDR_W-1:0]  dbg_addr;
    logic [SLICE_W-1:0] dbg_slice;
    logic [RF_AW-1:0]   rf_raddr;
    logic [DATA_W-1:0]  rf_rdata;
    logic               mem_rd_req;
    logic [ADDR_W-1:0]  mem_raddr;
    logic               mem_rd_ack;
    logic [DATA_W-1:0]  mem_rdata;
    logic [OUT_W-1:0]   out;
    logic [CYC_W-1:0]   cycle_cnt;
    logic [1:0]         dbg_state;

    int total = 0;
    int bad   = 0;
    int ce_seen  = 0;
    int req_seen = 0;
    int mark;

    logic [OUT_W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]        sel;
        logic [1:0]        slice;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       rf;
        logic [31:0]       pc;
        logic [15:0]       exp_out;
        logic [4:0]        exp_raddr;
    } vec_t;

    vec_t vecs[8];

    kgp_debug_ctrl #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .SLICE_W(SLICE_W), .ADDR_W(ADDR_W),
        .RF_AW(RF_AW), .PC_W(PC_W), .CYC_W(CYC_W), .AUTO_RUN(0)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt), .step(step),
        .bp_en(bp_en), .bp_addr(bp_addr), .core_pc(core_pc),
        .core_halt_instr(core_halt_instr), .core_ce(core_ce), .halted(halted),
        .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_slice(dbg_slice),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .mem_rd_req(mem_rd_req),
        .mem_raddr(mem_raddr), .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata),
        .out(out), .cycle_cnt(cycle_cnt), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && core_ce)    ce_seen++;
        if (!rst && mem_rd_req) req_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Driver / checker tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        logic [OUT_W-1:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, out=0x%0h", name, out);
        end else begin
            e = exp_q.pop_front();
            if (out !== e) begin
                bad++;
                $display("FAIL %s: out 0x%0h expected 0x%0h", name, out, e);
            end
        end
    endtask

    task automatic step_pulse();
        step = 1'b1;
        tick();
        chk("step_ce_high", 32'(core_ce), 32'd1);
        step = 1'b0;
        tick();
        chk("step_ce_low", 32'(core_ce), 32'd0);
    endtask

    initial begin
        vecs[0] = '{2'd0, 2'd0, 10'h003, 32'h1234_5678, 32'h0, 16'h5678, 5'h03};
        vecs[1] = '{2'd0, 2'd1, 10'h3E1, 32'h1234_5678, 32'h0, 16'h1234, 5'h01};
        vecs[2] = '{2'd0, 2'd2, 10'h01F, 32'h1234_5678, 32'h0, 16'h0000, 5'h1F};
        vecs[3] = '{2'd2, 2'd0, 10'h000, 32'h0,         32'hCAFE_F00D, 16'hF00D, 5'h00};
        vecs[4] = '{2'd2, 2'd1, 10'h000, 32'h0,         32'hCAFE_F00D, 16'hCAFE, 5'h00};
        vecs[5] = '{2'd2, 2'd3, 10'h000, 32'h0,         32'hCAFE_F00D, 16'h0000, 5'h00};
        vecs[6] = '{2'd0, 2'd1, 10'h2AA, 32'hA5A5_0000, 32'h0, 16'hA5A5, 5'h0A};
        vecs[7] = '{2'd0, 2'd0, 10'h155, 32'h0000_3C3C, 32'h0, 16'h3C3C, 5'h15};

        rst = 1'b1; run = 0; halt = 0; step = 0; bp_en = 0; bp_addr = '0;
        core_pc = '0; core_halt_instr = 0; dbg_sel = 2'd0; dbg_addr = '0;
        dbg_slice = '0; rf_rdata = '0; mem_rd_ack = 0; mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_ce", 32'(core_ce), 32'd0);
        chk("rst_req", 32'(mem_rd_req), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_cnt", 32'(cycle_cnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_HALT));

        // Three single steps
        mark = ce_seen;
        for (int i = 0; i < 3; i++) step_pulse();
        chk("step_ce_cycles", 32'(ce_seen - mark), 32'd3);
        chk("step_cnt", 32'(cycle_cnt), 32'd3);
        chk("step_halted", 32'(halted), 32'd1);

        // Breakpoint at 0x10, then resume through it once
        bp_en = 1'b1; bp_addr = 32'h10; core_pc = 32'h08; run = 1'b1;
        tick();
        chk("bp_run_ce", 32'(core_ce), 32'd1);
        run = 1'b0; core_pc = 32'h0C;
        tick();
        chk("bp_cnt4", 32'(cycle_cnt), 32'd4);
        chk("bp_ce_0c", 32'(core_ce), 32'd1);
        tick();
        core_pc = 32'h10;
        #1;
        chk("bp_hit_ce", 32'(core_ce), 32'd0);
        tick();
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_cnt5", 32'(cycle_cnt), 32'd5);
        run = 1'b1;
        tick();
        chk("bp_resume_ce", 32'(core_ce), 32'd1);
        run = 1'b0;
        tick();
        core_pc = 32'h14;
        chk("bp_exec_once_cnt", 32'(cycle_cnt), 32'd6);
        #1;
        chk("bp_next_ce", 32'(core_ce), 32'd1);
        halt = 1'b1;
        #1;
        chk("halt_ce_now", 32'(core_ce), 32'd0);
        tick();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_cnt", 32'(cycle_cnt), 32'd6);
        halt = 1'b0; bp_en = 1'b0;
        tick();

        // Data-memory read with a 4-cycle request
        mark = req_seen;
        dbg_sel = 2'd1; dbg_addr = 10'd5; dbg_slice = 2'd0;
        tick();
        chk("rd_req", 32'(mem_rd_req), 32'd1);
        chk("rd_addr", 32'(mem_raddr), 32'd5);
        tick();
        tick();
        tick();
        mem_rd_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        exp_q.push_back(16'hBEEF);
        tick();
        mem_rd_ack = 1'b0; mem_rdata = '0;
        chk("rd_req_cycles", 32'(req_seen - mark), 32'd4);
        chk("rd_req_drop", 32'(mem_rd_req), 32'd0);
        chk("rd_back_halted", 32'(halted), 32'd1);
        tick();
        sb_check("rd_slice0");
        dbg_slice = 2'd1; exp_q.push_back(16'hDEAD);
        tick();
        sb_check("rd_slice1");
        dbg_slice = 2'd2; exp_q.push_back(16'h0000);
        tick();
        sb_check("rd_slice2");
        chk("rd_no_retrigger", 32'(mem_rd_req), 32'd0);

        // Table-driven capture/window vectors (regfile and PC)
        for (int i = 0; i < 8; i++) begin
            dbg_sel = vecs[i].sel; dbg_slice = vecs[i].slice; dbg_addr = vecs[i].addr;
            rf_rdata = vecs[i].rf; core_pc = vecs[i].pc;
            exp_q.push_back(vecs[i].exp_out);
            #1;
            chk($sformatf("vec%0d_raddr", i), 32'(rf_raddr), 32'(vecs[i].exp_raddr));
            tick();
            tick();
            sb_check($sformatf("vec%0d_out", i));
        end

        // run+halt together, then run during READ_WAIT
        run = 1'b1; halt = 1'b1;
        tick();
        chk("runhalt_halted", 32'(halted), 32'd1);
        chk("runhalt_ce", 32'(core_ce), 32'd0);
        run = 1'b0; halt = 1'b0;
        dbg_sel = 2'd1; dbg_addr = 10'd7; dbg_slice = 2'd0;
        tick();
        chk("rw_req", 32'(mem_rd_req), 32'd1);
        run = 1'b1;
        tick();
        chk("rw_run_ignored", 32'(dbg_state), 32'(S_RDW));
        mem_rd_ack = 1'b1; mem_rdata = 32'h0000_1111;
        exp_q.push_back(16'h1111);
        tick();
        mem_rd_ack = 1'b0;
        chk("rw_ack_halted", 32'(halted), 32'd1);
        tick();
        sb_check("rw_out");
        chk("rw_then_run", 32'(dbg_state), 32'(S_RUN));
        dbg_sel = 2'd0; run = 1'b0; halt = 1'b1;
        #1;
        chk("rw_halt_ce", 32'(core_ce), 32'd0);
        tick();
        halt = 1'b0;

        // Counter wrap 15 -> 0 -> 1, then HALT opcode
        for (int i = 0; i < 8; i++) step_pulse();
        chk("wrap_pre", 32'(cycle_cnt), 32'd14);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk("wrap_15", 32'(cycle_cnt), 32'd15);
        tick();
        chk("wrap_0", 32'(cycle_cnt), 32'd0);
        tick();
        chk("wrap_1", 32'(cycle_cnt), 32'd1);
        core_halt_instr = 1'b1;
        #1;
        chk("hi_retires_ce", 32'(core_ce), 32'd1);
        tick();
        core_halt_instr = 1'b0;
        chk("hi_halted", 32'(halted), 32'd1);
        chk("hi_cnt", 32'(cycle_cnt), 32'd2);
        dbg_sel = 2'd3; dbg_slice = 2'd0;
        exp_q.push_back(16'h0002);
        tick();
        tick();
        sb_check("cyc_out");

        // Reset in the middle of READ_WAIT
        dbg_sel = 2'd1; dbg_addr = 10'd9;
        tick();
        chk("rr_req", 32'(mem_rd_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rr_req_drop", 32'(mem_rd_req), 32'd0);
        chk("rr_out", 32'(out), 32'd0);
        chk("rr_halted", 32'(halted), 32'd1);
        chk("rr_cnt", 32'(cycle_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rr_no_pending", 32'(mem_rd_req), 32'd0);
        chk("rr_state", 32'(dbg_state), 32'(S_HALT));

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
